control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit RISC datapath. It decodes the instruction word held in IR and steps through fetch and execute micro-steps. In each step it drives the register-select, bus-source, ALU-op, memory Read/Write and manual-bus-constant controls that the datapath consumes. It is the master on the datapath control interface; the datapath only responds.

---
 rtl/cpu_pkg.sv | 83 ++++++++
 rtl/select_encode.sv | 26 ++
 rtl/control_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: instruction field
// positions, opcodes, ALU codes, sequencer states and instruction classes.
package cpu_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C_HI  = 18;
    localparam int C_LO  = 0;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [2:0] {S_RST, S_F0, S_F1, S_F2, S_EX, S_HALT} state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LD, C_ST, C_MULDIV, C_UNARY,
        C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
    } iclass_t;

    // Group opcodes by the shape of their execute sequence.
    function automatic iclass_t classify(input logic [4:0] op);
        if (op >= OP_ADD && op <= OP_ROL)              return C_RTYPE;
        if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) return C_IMM;
        if (op == OP_LD)                               return C_LD;
        if (op == OP_ST)                               return C_ST;
        if (op == OP_MUL || op == OP_DIV)              return C_MULDIV;
        if (op == OP_NEG || op == OP_NOT)              return C_UNARY;
        if (op == OP_MFHI)                             return C_MFHI;
        if (op == OP_MFLO)                             return C_MFLO;
        if (op == OP_NOP)                              return C_NOP;
        if (op == OP_HALT)                             return C_HALT;
        return C_ILLEGAL;
    endfunction

    // Final execute step (T3..T7) of each class.
    function automatic logic [2:0] last_step(input iclass_t cls);
        case (cls)
            C_RTYPE, C_IMM: return 3'd5;
            C_LD, C_ST:     return 3'd7;
            C_MULDIV:       return 3'd6;
            C_UNARY:        return 3'd4;
            default:        return 3'd3;
        endcase
    endfunction

    // ALU operation used during the Zin step of each instruction.
    function automatic logic [4:0] alu_code(input logic [4:0] op, input iclass_t cls);
        case (cls)
            C_RTYPE, C_MULDIV, C_UNARY: return op;
            C_IMM: begin
                if (op == OP_ANDI) return ALU_AND;
                if (op == OP_ORI)  return ALU_OR;
                return ALU_ADD;
            end
            C_LD, C_ST: return ALU_ADD;
            default:    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/select_encode.sv
// Register-select encoder: picks one of Ra/Rb/Rc and decodes it to one-hot
// load (reg_in) and bus-drive (reg_out) enables for R0..R15.
module select_encode (
    input  logic [3:0]  Ra,
    input  logic [3:0]  Rb,
    input  logic [3:0]  Rc,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out
);
    logic [3:0]  sel;
    logic [15:0] dec;

    assign sel = ({4{Gra}} & Ra) | ({4{Grb}} & Rb) | ({4{Grc}} & Rc);

    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
        assign dec[gi] = (sel == 4'(gi));
    end

    assign reg_in  = dec & {16{Rin}};
    assign reg_out = dec & {16{Rout}};
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch F0/F1/F2, execute steps T3..T7 with a
// memory wait counter, and a Moore decode of state, step and IR to the
// datapath control strobes.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Yin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        MBIout,
    output logic [31:0] manual_bus,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);
    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t      state_q;
    logic [2:0]  step_q;
    logic [2:0]  wait_q;
    logic [4:0]  op;
    iclass_t     cls;
    logic        mem_step;
    logic        ex_done;
    logic        gra, grb, grc, rin_en, rout_en;

    assign op  = ir[OP_HI:OP_LO];
    assign cls = classify(op);

    // Steps that hold Read or Write while the wait counter drains.
    assign mem_step = (state_q == S_F1 && step_q == 3'd1) ||
                      (state_q == S_EX && ((cls == C_LD && step_q == 3'd6) ||
                                           (cls == C_ST && step_q == 3'd7)));
    assign ex_done  = (state_q == S_EX) && (step_q == last_step(cls)) &&
                      (!mem_step || wait_q == 3'd0);

    // Sequencer: state, step counter and memory wait counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
            step_q  <= 3'd0;
            wait_q  <= 3'd0;
        end else begin
            case (state_q)
                S_RST: state_q <= S_F0;
                S_F0: begin
                    state_q <= S_F1;
                    step_q  <= 3'd0;
                    wait_q  <= WAIT_INIT;
                end
                S_F1: begin
                    if (step_q == 3'd0) begin
                        step_q <= 3'd1;
                        wait_q <= WAIT_INIT;
                    end else if (wait_q == 3'd0) begin
                        state_q <= S_F2;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_F2: begin
                    if (cls == C_HALT)     state_q <= S_HALT;
                    else if (cls == C_NOP) state_q <= stop ? S_HALT : S_F0;
                    else begin
                        state_q <= S_EX;
                        step_q  <= 3'd3;
                        wait_q  <= WAIT_INIT;
                    end
                end
                S_EX: begin
                    if (ex_done) begin
                        state_q <= stop ? S_HALT : S_F0;
                    end else if (mem_step && wait_q != 3'd0) begin
                        wait_q <= wait_q - 3'd1;
                    end else begin
                        step_q <= step_q + 3'd1;
                        wait_q <= WAIT_INIT;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_RST;
            endcase
        end
    end

    // Moore decode of the control strobes; RST and HALT drive everything low.
    always_comb begin
        {HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout} = '0;
        {Yin, MARin, MDRin, MDRout, Read, Write, MBIout, run, illegal} = '0;
        {gra, grb, grc, rin_en, rout_en} = '0;
        manual_bus = 32'd0;
        alu_op     = 5'd0;
        case (state_q)
            S_F0: begin
                run = 1'b1; manual_bus = 32'd1;
                PCout = 1'b1; MARin = 1'b1; Yin = 1'b1;
            end
            S_F1: begin
                run = 1'b1; manual_bus = 32'd1;
                if (step_q == 3'd0) begin
                    MBIout = 1'b1; alu_op = ALU_ADD; Zin = 1'b1;
                end else begin
                    Read = 1'b1; MDRin = 1'b1;
                    if (wait_q == WAIT_INIT) begin
                        Zlowout = 1'b1; PCin = 1'b1;
                    end
                end
            end
            S_F2: begin
                run = 1'b1; manual_bus = 32'd1;
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_EX: begin
                run = 1'b1;
                manual_bus = {{13{ir[C_HI]}}, ir[C_HI:C_LO]};
                case (cls)
                    C_RTYPE, C_IMM, C_LD, C_ST: begin
                        if (step_q == 3'd3) begin
                            grb = 1'b1; rout_en = 1'b1; Yin = 1'b1;
                        end else if (step_q == 3'd4) begin
                            Zin = 1'b1; alu_op = alu_code(op, cls);
                            if (cls == C_RTYPE) begin grc = 1'b1; rout_en = 1'b1; end
                            else MBIout = 1'b1;
                        end else if (step_q == 3'd5) begin
                            Zlowout = 1'b1;
                            if (cls == C_LD || cls == C_ST) MARin = 1'b1;
                            else begin gra = 1'b1; rin_en = 1'b1; end
                        end else if (step_q == 3'd6) begin
                            MDRin = 1'b1;
                            if (cls == C_LD) Read = 1'b1;
                            else begin gra = 1'b1; rout_en = 1'b1; end
                        end else if (step_q == 3'd7) begin
                            if (cls == C_LD) begin
                                MDRout = 1'b1; gra = 1'b1; rin_en = 1'b1;
                            end else begin
                                Write = 1'b1;
                            end
                        end
                    end
                    C_MULDIV: begin
                        if (step_q == 3'd3) begin
                            gra = 1'b1; rout_en = 1'b1; Yin = 1'b1;
                        end else if (step_q == 3'd4) begin
                            grb = 1'b1; rout_en = 1'b1; Zin = 1'b1;
                            alu_op = alu_code(op, cls);
                        end else if (step_q == 3'd5) begin
                            Zlowout = 1'b1; LOin = 1'b1;
                        end else begin
                            Zhighout = 1'b1; HIin = 1'b1;
                        end
                    end
                    C_UNARY: begin
                        if (step_q == 3'd3) begin
                            grb = 1'b1; rout_en = 1'b1; Zin = 1'b1;
                            alu_op = alu_code(op, cls);
                        end else begin
                            Zlowout = 1'b1; gra = 1'b1; rin_en = 1'b1;
                        end
                    end
                    C_MFHI: begin HIout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
                    C_MFLO: begin LOout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
                    C_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    select_encode u_select (
        .Ra      (ir[RA_HI:RA_LO]),
        .Rb      (ir[RB_HI:RB_LO]),
        .Rc      (ir[RC_HI:RC_LO]),
        .Gra     (gra),
        .Grb     (grb),
        .Grc     (grc),
        .Rin     (rin_en),
        .Rout    (rout_en),
        .reg_in  (reg_in),
        .reg_out (reg_out)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT 0 and 2) checked
// cycle by cycle against a micro-step table model built from the ISA rules.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic hiin, hiout, loin, loout, pcin, pcout, irin, zin, zhi, zlo, yin, marin, mdrin, mdrout;
        logic rd, wr, mbi;
        logic [31:0] mb;
        logic [4:0]  alu;
        logic run, ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic [1:0]  clr_n = 2'b00;
    logic [31:0] ir_s [2];
    logic [1:0]  stop_s = 2'b00;
    ctl_t        obs [2];

    int checks = 0;
    int errors = 0;
    ctl_t exp_q[$];
    ctl_t obs_q[$];

    logic [4:0] op_tab [23] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd24,
                                5'd25, 5'd26, 5'd1, 5'd18, 5'd31};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [15:0] reg_in, reg_out;
        logic HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin, Zhighout, Zlowout;
        logic Yin, MARin, MDRin, MDRout, Read, Write, MBIout, run, illegal;
        logic [31:0] manual_bus;
        logic [4:0]  alu_op;

        control_sequencer #(.MEM_WAIT(gi * 2)) dut (
            .clk(clk), .clr(clr_n[gi]), .ir(ir_s[gi]), .stop(stop_s[gi]),
            .reg_in(reg_in), .reg_out(reg_out),
            .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
            .PCin(PCin), .PCout(PCout), .IRin(IRin), .Zin(Zin),
            .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin), .MARin(MARin),
            .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
            .MBIout(MBIout), .manual_bus(manual_bus), .alu_op(alu_op),
            .run(run), .illegal(illegal)
        );

        assign obs[gi] = {reg_in, reg_out, HIin, HIout, LOin, LOout, PCin, PCout, IRin, Zin,
                          Zhighout, Zlowout, Yin, MARin, MDRin, MDRout, Read, Write, MBIout,
                          manual_bus, alu_op, run, illegal};
    end

    function automatic ctl_t blank(input logic [31:0] mb);
        ctl_t c;
        c = '0;
        c.run = 1'b1;
        c.mb = mb;
        return c;
    endfunction

    // Expected per-cycle controls for one instruction, from F0 to its last step.
    task automatic build_model(input int k, input logic [31:0] instr);
        int w;
        logic [4:0] op;
        logic [31:0] sx;
        logic [15:0] ra1, rb1, rc1;
        ctl_t c;
        w   = k * 2;
        op  = instr[31:27];
        sx  = {{13{instr[18]}}, instr[18:0]};
        ra1 = 16'd1 << instr[26:23];
        rb1 = 16'd1 << instr[22:19];
        rc1 = 16'd1 << instr[18:15];
        exp_q.delete();
        c = blank(32'd1); c.pcout = 1; c.marin = 1; c.yin = 1; exp_q.push_back(c);
        c = blank(32'd1); c.mbi = 1; c.alu = 5'd3; c.zin = 1; exp_q.push_back(c);
        for (int i = 0; i <= w; i++) begin
            c = blank(32'd1); c.rd = 1; c.mdrin = 1;
            if (i == 0) begin c.zlo = 1; c.pcin = 1; end
            exp_q.push_back(c);
        end
        c = blank(32'd1); c.mdrout = 1; c.irin = 1; exp_q.push_back(c);
        if (op >= 5'd3 && op <= 5'd10) begin
            c = blank(sx); c.rout = rb1; c.yin = 1; exp_q.push_back(c);
            c = blank(sx); c.rout = rc1; c.zin = 1; c.alu = op; exp_q.push_back(c);
            c = blank(sx); c.zlo = 1; c.rin = ra1; exp_q.push_back(c);
        end else if (op == 5'd0 || op == 5'd2 || (op >= 5'd11 && op <= 5'd13)) begin
            c = blank(sx); c.rout = rb1; c.yin = 1; exp_q.push_back(c);
            c = blank(sx); c.mbi = 1; c.zin = 1;
            c.alu = (op == 5'd12) ? 5'd5 : (op == 5'd13) ? 5'd6 : 5'd3;
            exp_q.push_back(c);
            c = blank(sx); c.zlo = 1;
            if (op >= 5'd11) c.rin = ra1; else c.marin = 1;
            exp_q.push_back(c);
            if (op == 5'd0) begin
                for (int i = 0; i <= w; i++) begin
                    c = blank(sx); c.rd = 1; c.mdrin = 1; exp_q.push_back(c);
                end
                c = blank(sx); c.mdrout = 1; c.rin = ra1; exp_q.push_back(c);
            end else if (op == 5'd2) begin
                c = blank(sx); c.rout = ra1; c.mdrin = 1; exp_q.push_back(c);
                for (int i = 0; i <= w; i++) begin
                    c = blank(sx); c.wr = 1; exp_q.push_back(c);
                end
            end
        end else if (op == 5'd14 || op == 5'd15) begin
            c = blank(sx); c.rout = ra1; c.yin = 1; exp_q.push_back(c);
            c = blank(sx); c.rout = rb1; c.zin = 1; c.alu = op; exp_q.push_back(c);
            c = blank(sx); c.zlo = 1; c.loin = 1; exp_q.push_back(c);
            c = blank(sx); c.zhi = 1; c.hiin = 1; exp_q.push_back(c);
        end else if (op == 5'd16 || op == 5'd17) begin
            c = blank(sx); c.rout = rb1; c.zin = 1; c.alu = op; exp_q.push_back(c);
            c = blank(sx); c.zlo = 1; c.rin = ra1; exp_q.push_back(c);
        end else if (op == 5'd24 || op == 5'd25) begin
            c = blank(sx); c.hiout = (op == 5'd24); c.loout = (op == 5'd25); c.rin = ra1;
            exp_q.push_back(c);
        end else if (op != 5'd26 && op != 5'd27) begin
            c = blank(sx); c.ill = 1; exp_q.push_back(c);
        end
    endtask

    // Apply one instruction from F0 and record the observed controls per cycle.
    task automatic drive_instr(input int k, input logic [31:0] instr, input logic stp);
        build_model(k, instr);
        obs_q.delete();
        ir_s[k] = instr;
        stop_s[k] = stp;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            obs_q.push_back(obs[k]);
            @(negedge clk);
        end
        stop_s[k] = 1'b0;
    endtask

    task automatic test_reset(input int k);
        @(negedge clk);
        clr_n[k] = 1'b0;
        #1;
        checks++;
        if (obs[k] !== '0) begin
            errors++; $display("FAIL reset_async k=%0d got=%h want=0", k, obs[k]);
        end
        @(negedge clk); #1;
        checks++;
        if (obs[k] !== '0) begin
            errors++; $display("FAIL reset_hold k=%0d got=%h want=0", k, obs[k]);
        end
        clr_n[k] = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (!(obs[k].pcout && obs[k].marin && obs[k].yin && obs[k].run && !obs[k].rd)) begin
            errors++; $display("FAIL first_f0 k=%0d got=%h want PCout,MARin,Yin,run", k, obs[k]);
        end
        $display("reset k=%0d done", k);
    endtask

    task automatic test_add();
        logic [31:0] instr;
        instr = 32'h1989_0000; // add R3,R1,R2
        drive_instr(0, instr, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL add_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (!(obs_q[4].rout == 16'h0002 && obs_q[4].yin && obs_q[5].rout == 16'h0004 &&
              obs_q[5].zin && obs_q[5].alu == 5'b00011 && obs_q[6].rin == 16'h0008 &&
              obs_q[6].zlo && !obs_q[6].pcout)) begin
            errors++; $display("FAIL add_literal t3=%h t4=%h t5=%h", obs_q[4], obs_q[5], obs_q[6]);
        end
        #1;
        checks++;
        if (!obs[0].pcout) begin
            errors++; $display("FAIL add_next_f0 got=%h want PCout after 7 cycles", obs[0]);
        end
        $display("add ir=%h cycles=%0d", instr, obs_q.size());
    endtask

    task automatic test_mul();
        logic [31:0] instr;
        instr = 32'h7188_0000; // mul R3,R1
        drive_instr(0, instr, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mul_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (!(obs_q[6].loin && obs_q[6].zlo && !obs_q[6].zhi &&
              obs_q[7].hiin && obs_q[7].zhi && !obs_q[7].zlo && obs_q[7].run)) begin
            errors++; $display("FAIL mul_lohi t5=%h t6=%h", obs_q[6], obs_q[7]);
        end
        $display("mul ir=%h cycles=%0d", instr, obs_q.size());
    endtask

    task automatic test_illegal();
        logic [31:0] instr;
        int n;
        instr = {5'b10010, 27'h0123456};
        drive_instr(0, instr, 1'b0);
        n = 0;
        foreach (obs_q[i]) if (obs_q[i].ill) n++;
        checks++;
        if (n != 1 || !obs_q[4].ill) begin
            errors++; $display("FAIL illegal_pulse count=%0d want 1 at T3", n);
        end
        #1;
        checks++;
        if (!obs[0].pcout) begin
            errors++; $display("FAIL illegal_next_f0 got=%h want PCout", obs[0]);
        end
        $display("illegal ir=%h cycles=%0d", instr, obs_q.size());
    endtask

    task automatic test_ld();
        logic [31:0] instr;
        int n;
        instr = 32'h0100_0065; // ld R2, 0x65(R0)
        drive_instr(1, instr, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ld_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        n = 0;
        for (int i = 9; i < 13; i++) if (obs_q[i].rd) n++;
        checks++;
        if (!(obs_q[7].mb == 32'h0000_0065 && obs_q[7].mbi && n == 3 &&
              obs_q[12].mdrout && obs_q[12].rin == 16'h0004)) begin
            errors++; $display("FAIL ld_literal t4=%h reads=%0d t7=%h", obs_q[7], n, obs_q[12]);
        end
        #1;
        checks++;
        if (!obs[1].pcout) begin
            errors++; $display("FAIL ld_next_f0 got=%h want PCout after 13 cycles", obs[1]);
        end
        $display("ld ir=%h cycles=%0d", instr, obs_q.size());
    endtask

    task automatic test_st();
        logic [31:0] instr;
        int nw, nov;
        instr = 32'h1208_0010; // st R4, 0x10(R1)
        drive_instr(1, instr, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL st_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        nw = 0; nov = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].wr) nw++;
            if (obs_q[i].wr && obs_q[i].rd) nov++;
        end
        checks++;
        if (!(obs_q[9].rout == 16'h0010 && obs_q[9].mdrin && !obs_q[9].rd && nw == 3 && nov == 0)) begin
            errors++; $display("FAIL st_literal t6=%h writes=%0d overlap=%0d", obs_q[9], nw, nov);
        end
        $display("st ir=%h cycles=%0d", instr, obs_q.size());
    endtask

    task automatic test_random(input int k, input int n);
        logic [31:0] instr;
        int bad;
        for (int t = 0; t < n; t++) begin
            instr = {op_tab[$urandom_range(0, 22)], 27'($urandom)};
            drive_instr(k, instr, 1'b0);
            bad = 0;
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; bad++;
                    $display("FAIL rand k=%0d ir=%h step%0d got=%h want=%h", k, instr, i, obs_q[i], exp_q[i]);
                end
            end
            $display("rand k=%0d ir=%h cycles=%0d bad=%0d", k, instr, obs_q.size(), bad);
        end
    endtask

    task automatic test_stop();
        logic [31:0] instr;
        instr = {5'b00011, 27'($urandom)};
        drive_instr(0, instr, 1'b1);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stop_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs[0] !== '0) begin
                errors++; $display("FAIL stop_halt cyc%0d got=%h want=0", i, obs[0]);
            end
            @(negedge clk);
        end
        $display("stop during add ir=%h -> halt", instr);
    endtask

    task automatic test_halt();
        logic [31:0] instr;
        instr = {5'b11011, 27'($urandom)};
        drive_instr(1, instr, 1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL halt_step%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            stop_s[1] = i[0];
            #1;
            checks++;
            if (obs[1] !== '0) begin
                errors++; $display("FAIL halt_persist cyc%0d got=%h want=0", i, obs[1]);
            end
            @(negedge clk);
        end
        stop_s[1] = 1'b0;
        $display("halt opcode held 20 cycles");
    endtask

    task automatic test_clr_mid_st();
        bit found;
        test_reset(1);
        ir_s[1] = 32'h1208_0010;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (obs[1].wr) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL clr_st_timeout no Write within 40 cycles");
        end else begin
            #1;
            clr_n[1] = 1'b0;
            #1;
            checks++;
            if (obs[1] !== '0) begin
                errors++; $display("FAIL clr_st_drop got=%h want=0", obs[1]);
            end
            @(negedge clk);
            clr_n[1] = 1'b1;
            @(negedge clk); #1;
            checks++;
            if (!(obs[1].pcout && obs[1].run && !obs[1].wr)) begin
                errors++; $display("FAIL clr_st_restart got=%h want F0", obs[1]);
            end
        end
        $display("clr during st write, restart checked");
    endtask

    initial begin
        ir_s[0] = 32'd0;
        ir_s[1] = 32'd0;
        test_reset(0);
        test_add();
        test_mul();
        test_illegal();
        test_random(0, 30);
        test_stop();
        test_reset(1);
        test_ld();
        test_st();
        test_random(1, 30);
        test_halt();
        test_clr_mid_st();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
